mux_arb_nto1: RTL

//  Parametrised N-to-1 data multiplexer with per-channel valid/ready handshakes and a registered output stage.

---
 rtl/mux_arb_pkg.sv | 36 +++
 rtl/mux_arb_nto1_rr_grant.sv | 28 ++
 rtl/mux_arb_nto1.sv | 89 ++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N-to-1 arbitrated multiplexer: selection modes
// and the circular first-set search used by the priority and round-robin arbiters.
package mux_arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;
  localparam int MODE_SEL   = 2;

  // Widest request vector the search helper handles; NCH must not exceed it.
  localparam int MAX_NCH = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // First set bit of vec[n-1:0] at or after start, wrapping n-1 -> 0.
  // Walking offsets from high to low lets the smallest offset win last.
  function automatic pick_t first_set_from(input logic [MAX_NCH-1:0] vec,
                                           input logic [5:0]         start,
                                           input logic [5:0]         n);
    pick_t      r;
    logic [6:0] idx;
    r = '0;
    for (int k = MAX_NCH - 1; k >= 0; k--) begin
      idx = {1'b0, start} + 7'(k);
      if (idx >= {1'b0, n}) idx = idx - {1'b0, n};
      if ((7'(k) < {1'b0, n}) && vec[idx[4:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[4:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_grant.sv
// Circular-priority grant: one-hot grant to the first request at or after ptr.
// With ptr tied to zero this is a plain lowest-index-wins priority arbiter.
module rr_grant
  import mux_arb_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_any
);

  logic [MAX_NCH-1:0] req_pad;
  pick_t              pick;

  always_comb begin
    req_pad            = '0;
    req_pad[NCH-1:0]   = req;
    pick               = first_set_from(req_pad, 6'(ptr), 6'(NCH));
    grant_any          = pick.found;
    grant_idx          = SELW'(pick.idx);
    grant              = pick.found ? (NCH'(1) << pick.idx) : '0;
  end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-to-1 multiplexer with valid/ready on every channel and a one-word registered
// output stage; channel choice is fixed priority, round-robin or external select.
module mux_arb_nto1
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int MODE  = 1,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             load;
  logic             transfer;
  logic             arb_any;
  logic             sel_hit;
  logic [NCH-1:0]   arb_grant;
  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  arb_idx;
  logic [SELW-1:0]  grant_idx;
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  arb_ptr;
  logic [SELW-1:0]  ptr_next;
  logic [WIDTH-1:0] chan [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign chan[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Fixed priority reuses the circular arbiter with its start point pinned at 0.
  assign arb_ptr = (MODE == MODE_RR) ? ptr : '0;

  rr_grant #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (arb_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  assign sel_hit = ({1'b0, sel} < (SELW+1)'(NCH)) && in_valid[sel];

  always_comb begin
    if (MODE == MODE_SEL) begin
      grant     = sel_hit ? (NCH'(1) << sel) : '0;
      grant_idx = sel;
    end else begin
      grant     = arb_grant;
      grant_idx = arb_idx;
    end
  end

  // The store can take a word when it is empty or is being emptied this cycle.
  assign load     = enable & (~out_valid | out_ready);
  assign transfer = load & ((MODE == MODE_SEL) ? sel_hit : arb_any);
  assign in_ready = (load && !reset) ? grant : '0;
  assign ptr_next = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= chan[grant_idx];
      out_ch    <= grant_idx;
      ptr       <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
